// File: rtl/trigger_conditioner_pkg.sv
// Shared definitions for the trigger conditioner: state encoding, default
// timing parameters and a small elaboration-time helper.
// Optional feature macro used by this block: TRIG_COUNT_EN.
package trigger_pkg;

   // State encoding, kept as plain constants so legacy tooling and
   // downstream debug scripts can decode the raw 3-bit register.
   typedef logic [2:0] state_t;

   localparam state_t IDLE         = 3'd0;
   localparam state_t DEBOUNCE     = 3'd1;
   localparam state_t FIRE         = 3'd2;
   localparam state_t HOLDOFF      = 3'd3;
   localparam state_t WAIT_RELEASE = 3'd4;

   // Defaults: four stable cycles to qualify a press; hold-off spans the
   // sequencer's S1..S5 run plus one cycle of margin.
   localparam int DEBOUNCE_CYCLES_DEF = 4;
   localparam int HOLDOFF_CYCLES_DEF  = 6;
   localparam int CNT_W_DEF           = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/trigger_conditioner_if.sv
// Button-side bundle of the trigger conditioner. The master side owns the
// raw button level; the slave side (the conditioner) returns the clean start
// pulse and status. The trigger counter exists only with TRIG_COUNT_EN.
interface trigger_conditioner_if
`ifdef TRIG_COUNT_EN
   #(parameter int CNT_W = trigger_pkg::CNT_W_DEF)
`endif
   ();

   import trigger_pkg::*;

   logic btn_raw;
   logic trig_out;
   logic busy;
`ifdef TRIG_COUNT_EN
   logic [CNT_W-1:0] trig_count;

   modport master (output btn_raw, input trig_out, input busy, input trig_count);
   modport slave  (input btn_raw, output trig_out, output busy, output trig_count);
`else
   modport master (output btn_raw, input trig_out, input busy);
   modport slave  (input btn_raw, output trig_out, output busy);
`endif

endinterface

// File: rtl/trigger_conditioner_sync2_ff.sv
// Two-flop synchronizer for a single asynchronous level. Reusable for any
// slow asynchronous input; both stages clear to 0 on reset.
module sync2_ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Shift the raw level through two stages; only the second is safe to use.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: flops are written with <= so every stage samples the value from
      // before the edge; blocking here would collapse the chain into one flop.
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/trigger_conditioner.sv
// Trigger conditioner: turns a bouncy asynchronous push-button level into a
// single-cycle start pulse for the sequence generator. The button is
// synchronized, debounced, fired once, then locked out for a hold-off period
// and until release. Define TRIG_COUNT_EN to add a pulse counter.
module trigger_conditioner
   import trigger_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input logic                  clk,
   input logic                  reset_b,
   trigger_conditioner_if.slave bus
);

   // One counter serves both the debounce and the hold-off phases.
   localparam int CW = $clog2(max_int(DEBOUNCE_CYCLES, HOLDOFF_CYCLES) + 1);

   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES);

   // Reject illegal configurations at elaboration.
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 2");
   end
   if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
      $error("HOLDOFF_CYCLES must be at least 1");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   logic          w_btn_s;
   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;

   sync2_ff u_sync (
      .clk   (clk),
      .rst_n (reset_b),
      .i_d   (bus.btn_raw),
      .o_q   (w_btn_s)
   );

   // Next-state and counter decode; only the synchronized level is used.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_btn_s) begin
               w_state_nxt = DEBOUNCE;
               w_cnt_nxt   = CNT_ONE;
            end
         end
         DEBOUNCE: begin
            if (!w_btn_s) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == DEB_LAST) begin
               w_state_nxt = FIRE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         FIRE: begin
            w_state_nxt = HOLDOFF;
            w_cnt_nxt   = CNT_ONE;
         end
         HOLDOFF: begin
            // The button is ignored here so the downstream sequence always
            // runs to completion.
            if (r_cnt == HOLD_LAST) begin
               w_state_nxt = WAIT_RELEASE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         WAIT_RELEASE: begin
            if (!w_btn_s) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // State and counter registers; reset aborts any activity straight to IDLE.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Outputs come from the state register only: no path from btn_raw.
   assign bus.trig_out = (r_state == FIRE);
   assign bus.busy     = (r_state != IDLE);

`ifdef TRIG_COUNT_EN
   logic [CNT_W-1:0] r_trig_count;

   // Count issued pulses; wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_trig_count <= '0;
      end else if (r_state == FIRE) begin
         r_trig_count <= r_trig_count + 1'b1;
      end
   end

   assign bus.trig_count = r_trig_count;
`endif

endmodule
